// File: rtl/engine_tone_decoder_if.sv
// Signal bundle between the tone decoder and whatever feeds/consumes it.
// master is the decoder side; slave drives the tone and reads the results.
interface engine_tone_decoder_if;
    // No valid/ready handshake: level_out is meaningful only while level_valid is 1,
    // and level_strobe is a single-cycle pulse when level_valid rises or level_out changes.
    logic       tone_in;
    logic [3:0] level_out;
    logic       level_valid;
    logic       level_strobe;
    logic       tone_present;
    logic [1:0] state_dbg;

    modport master (
        input  tone_in,
        output level_out, level_valid, level_strobe, tone_present, state_dbg
    );

    modport slave (
        output tone_in,
        input  level_out, level_valid, level_strobe, tone_present, state_dbg
    );
endinterface

// File: rtl/engine_tone_decoder.sv
// Measures the half-period of an incoming square-wave tone and decodes it to the
// 4-bit speed level of the engine_sound generator, with confirmation and timeout.
module engine_tone_decoder #(
    parameter int CLK_FREQ_HZ    = 1_000_000,
    parameter int BASE_TONE_HZ   = 200,
    parameter int STEP_TONE_HZ   = 150,
    parameter int TOL_CYCLES     = 3,
    parameter int CONFIRM_COUNT  = 4,
    parameter int TIMEOUT_CYCLES = 8192
) (
    input  logic                  clk,
    input  logic                  rst,
    engine_tone_decoder_if.master bus
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARM   = 2'd1;
    localparam logic [1:0] ST_TRACK = 2'd2;

    localparam int                CONF_W   = $clog2(CONFIRM_COUNT + 1);
    localparam logic [CONF_W-1:0] CONF_MAX = CONF_W'(CONFIRM_COUNT);

    function automatic logic [15:0] half_period(input int lvl);
        return 16'(CLK_FREQ_HZ / (2 * (BASE_TONE_HZ + lvl * STEP_TONE_HZ)));
    endfunction

    logic [15:0] h_tab [16];
    for (genvar g = 0; g < 16; g++) begin : g_tab
        assign h_tab[g] = half_period(g);
    end

    logic              sync1, sync2, sync_d;
    logic              edge_det;
    logic [15:0]       cnt;
    logic [16:0]       meas;
    logic [1:0]        state;
    logic [3:0]        held;
    logic [CONF_W-1:0] conf_cnt;
    logic [3:0]        level_q;
    logic              valid_q, strobe_q, present_q;

    logic [16:0]       diff, best_err;
    logic [3:0]        cand;
    logic              accepted;
    logic [3:0]        held_next;
    logic [CONF_W-1:0] conf_next;
    logic              fire;
    logic              timeout_hit;

    // Both polarities count: a half-period is the time between any two transitions.
    assign edge_det    = sync2 ^ sync_d;
    assign meas        = {1'b0, cnt} + 17'd1;
    assign timeout_hit = (cnt >= 16'(TIMEOUT_CYCLES - 1));

    // Nearest table entry; strict '<' keeps the lower level on a tie.
    always_comb begin
        diff     = '0;
        best_err = '1;
        cand     = '0;
        for (int i = 0; i < 16; i++) begin
            diff = (meas >= {1'b0, h_tab[i]}) ? meas - {1'b0, h_tab[i]}
                                               : {1'b0, h_tab[i]} - meas;
            if (diff < best_err) begin
                best_err = diff;
                cand     = 4'(i);
            end
        end
        accepted = (best_err <= 17'(TOL_CYCLES));
    end

    always_comb begin
        held_next = held;
        conf_next = conf_cnt;
        if (cand == held) begin
            conf_next = (conf_cnt >= CONF_MAX) ? CONF_MAX : conf_cnt + 1'b1;
        end else begin
            held_next = cand;
            conf_next = CONF_W'(1);
        end
        fire = (conf_next == CONF_MAX) && (!valid_q || level_q != held_next);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            sync_d    <= 1'b0;
            cnt       <= '0;
            state     <= ST_IDLE;
            held      <= '0;
            conf_cnt  <= '0;
            level_q   <= '0;
            valid_q   <= 1'b0;
            strobe_q  <= 1'b0;
            present_q <= 1'b0;
        end else begin
            sync1    <= bus.tone_in;
            sync2    <= sync1;
            sync_d   <= sync2;
            strobe_q <= 1'b0;

            if (edge_det) begin
                cnt <= '0;
            end else if (cnt != 16'hFFFF) begin
                cnt <= cnt + 16'd1;
            end

            case (state)
                ST_IDLE: begin
                    if (edge_det) state <= ST_ARM;
                end
                ST_ARM, ST_TRACK: begin
                    // An edge landing on the timeout cycle is still a valid measurement.
                    if (edge_det) begin
                        state     <= ST_TRACK;
                        present_q <= 1'b1;
                        if (accepted) begin
                            held     <= held_next;
                            conf_cnt <= conf_next;
                            if (fire) begin
                                level_q  <= held_next;
                                valid_q  <= 1'b1;
                                strobe_q <= 1'b1;
                            end
                        end else begin
                            conf_cnt <= '0;
                            valid_q  <= 1'b0;
                        end
                    end else if (timeout_hit) begin
                        state     <= ST_IDLE;
                        present_q <= 1'b0;
                        valid_q   <= 1'b0;
                        conf_cnt  <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.level_out    = level_q;
    assign bus.level_valid  = valid_q;
    assign bus.level_strobe = strobe_q;
    assign bus.tone_present = present_q;
    assign bus.state_dbg    = state;
endmodule

// File: tb/tb_engine_tone_decoder.sv
// Bench for engine_tone_decoder: directed segment table, timeout and reset
// sequences, a level sweep and randomized jittered streams against a model.
module tb_engine_tone_decoder;
    localparam int         T_OUT     = 8192;
    localparam int         TOL       = 3;
    localparam int         CONF      = 4;
    localparam logic [1:0] IDLE_CODE = 2'd0;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    engine_tone_decoder_if bus();
    engine_tone_decoder dut (.clk(clk), .rst(rst), .bus(bus));

    int checks   = 0;
    int failures = 0;
    int h_tab [16];
    logic [3:0] exp_q [$];

    // Reference model state, in terms of edges and measurements.
    bit m_armed, m_present, m_valid;
    int m_level, m_held, m_run, m_strobe;
    int seen_strobes, seg_strobes;

    typedef struct {
        int hp;
        int n;
        bit e_present;
        bit e_valid;
        int e_level;
        int e_strobes;
    } seg_t;
    seg_t segs [11];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int nearest(input int m);
        int best = 0;
        for (int l = 1; l < 16; l++)
            if (iabs(m - h_tab[l]) < iabs(m - h_tab[best])) best = l;
        return best;
    endfunction

    task automatic model_reset();
        m_armed = 0; m_present = 0; m_valid = 0;
        m_level = 0; m_held = 0; m_run = 0; m_strobe = 0;
        exp_q.delete();
    endtask

    task automatic model_timeout();
        m_armed = 0; m_present = 0; m_valid = 0; m_run = 0; m_strobe = 0;
    endtask

    task automatic model_edge(input int m);
        int c;
        m_strobe = 0;
        if (!m_armed) begin
            m_armed = 1;
            return;
        end
        m_present = 1;
        c = nearest(m);
        if (iabs(m - h_tab[c]) <= TOL) begin
            if (c == m_held) m_run = (m_run < CONF) ? m_run + 1 : CONF;
            else begin
                m_held = c;
                m_run  = 1;
            end
            if (m_run == CONF && (!m_valid || m_level != m_held)) begin
                m_level  = m_held;
                m_valid  = 1;
                m_strobe = 1;
                exp_q.push_back(4'(m_held));
            end
        end else begin
            m_run   = 0;
            m_valid = 0;
        end
    endtask

    task automatic sample_strobe();
        if (bus.level_strobe) begin
            seen_strobes++;
            seg_strobes++;
            if (exp_q.size() == 0) check("strobe_unexpected", 1, 0);
            else check("strobe_level", int'(bus.level_out), int'(exp_q.pop_front()));
        end
    endtask

    // Toggle the tone hp cycles after the previous toggle, then check 8 cycles later.
    task automatic step(input int hp);
        seen_strobes = 0;
        repeat (hp - 8) begin
            @(negedge clk);
            sample_strobe();
        end
        bus.tone_in = ~bus.tone_in;
        model_edge(hp);
        repeat (8) begin
            @(negedge clk);
            sample_strobe();
        end
        check("step_strobes", seen_strobes, m_strobe);
        check("step_present", int'(bus.tone_present), int'(m_present));
        check("step_valid", int'(bus.level_valid), int'(m_valid));
        check("step_level", int'(bus.level_out), m_level);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_level"}, int'(bus.level_out), 0);
        check({tag, "_valid"}, int'(bus.level_valid), 0);
        check({tag, "_strobe"}, int'(bus.level_strobe), 0);
        check({tag, "_present"}, int'(bus.tone_present), 0);
        check({tag, "_state"}, int'(bus.state_dbg), int'(IDLE_CODE));
    endtask

    initial begin
        int bad, lvl, n, hp;
        for (int l = 0; l < 16; l++) h_tab[l] = 1000000 / (2 * (200 + 150 * l));

        segs[0]  = '{526, 6, 1, 1, 5, 1};   // arm + 4 confirms: level 5 appears
        segs[1]  = '{526, 3, 1, 1, 5, 0};   // steady input, no more strobes
        segs[2]  = '{294, 3, 1, 1, 5, 0};   // new level confirming, old one still shown
        segs[3]  = '{294, 1, 1, 1, 10, 1};  // 4th measurement switches to 10
        segs[4]  = '{480, 1, 1, 0, 10, 0};  // glitch interval rejected
        segs[5]  = '{294, 3, 1, 0, 10, 0};
        segs[6]  = '{294, 1, 1, 1, 10, 1};  // recovered after 4 good measurements
        segs[7]  = '{206, 4, 1, 1, 15, 1};  // error 2 against 204
        segs[8]  = '{211, 3, 1, 0, 15, 0};  // error >= 6 to any entry
        segs[9]  = '{220, 4, 1, 1, 14, 1};  // error exactly TOL against 217
        segs[10] = '{200, 1, 1, 0, 14, 0};  // error TOL+1 against 204

        rst = 1'b1;
        bus.tone_in = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        bad = 0;
        repeat (20000) begin
            @(negedge clk);
            if (bus.level_out != 0 || bus.level_valid || bus.level_strobe ||
                bus.tone_present || bus.state_dbg != IDLE_CODE) bad++;
        end
        check("idle_hold_bad_cycles", bad, 0);

        for (int i = 0; i < 11; i++) begin
            seg_strobes = 0;
            for (int k = 0; k < segs[i].n; k++) step(segs[i].hp);
            check($sformatf("seg%0d_present", i), int'(bus.tone_present), int'(segs[i].e_present));
            check($sformatf("seg%0d_valid", i), int'(bus.level_valid), int'(segs[i].e_valid));
            check($sformatf("seg%0d_level", i), int'(bus.level_out), segs[i].e_level);
            check($sformatf("seg%0d_strobes", i), seg_strobes, segs[i].e_strobes);
        end

        // Loss of tone: last edge is processed 3 cycles after its toggle.
        repeat (4) step(294);
        check("pre_timeout_level", int'(bus.level_out), 10);
        repeat (T_OUT + 2 - 8) @(negedge clk);
        check("timeout_edge_minus1_present", int'(bus.tone_present), 1);
        @(negedge clk);
        check("timeout_present", int'(bus.tone_present), 0);
        check("timeout_valid", int'(bus.level_valid), 0);
        check("timeout_level_hold", int'(bus.level_out), 10);
        check("timeout_state", int'(bus.state_dbg), int'(IDLE_CODE));
        model_timeout();

        seg_strobes = 0;
        repeat (5) step(h_tab[1]);
        check("restart_level", int'(bus.level_out), 1);
        check("restart_valid", int'(bus.level_valid), 1);
        check("restart_strobes", seg_strobes, 1);

        for (int j = 0; j < 15; j++) begin
            lvl = (j < 14) ? j + 2 : 0;
            seg_strobes = 0;
            repeat (4) step(h_tab[lvl]);
            check($sformatf("sweep%0d_level", lvl), int'(bus.level_out), lvl);
            check($sformatf("sweep%0d_valid", lvl), int'(bus.level_valid), 1);
            check($sformatf("sweep%0d_strobes", lvl), seg_strobes, 1);
        end

        // Asynchronous reset in the middle of tracking.
        repeat (2) step(294);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_all_zero("async_reset");
        bus.tone_in = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (5) step(217);
        check("post_reset_level", int'(bus.level_out), 14);
        check("post_reset_valid", int'(bus.level_valid), 1);

        for (int b = 0; b < 3; b++) begin
            lvl = $urandom_range(10, 15);
            n   = $urandom_range(4, 6);
            for (int k = 0; k < n; k++) begin
                hp = h_tab[lvl] + $urandom_range(0, 6) - 3;
                if ($urandom_range(0, 5) == 0) hp = h_tab[lvl] + 6;
                step(hp);
            end
        end

        check("scoreboard_drain", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
